// File: rtl/sync_fifo_mw.sv
// Synchronous multi-word FIFO: pushes 0..WMAX and pops 0..RMAX words per cycle,
// with all-or-nothing acceptance, threshold flags and sticky error flags.
module sync_fifo_mw #(
  parameter int DW     = 32,
  parameter int DL     = 3,
  parameter int WMAX   = 2,
  parameter int RMAX   = 2,
  parameter int AF_LVL = (1 << DL) - WMAX,
  parameter int AE_LVL = RMAX,
  parameter int CW     = $clog2(((WMAX > RMAX) ? WMAX : RMAX) + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clr,
  input  logic [CW-1:0]      wr_cnt,
  input  logic [WMAX*DW-1:0] wdata,
  output logic               wr_acc,
  input  logic [CW-1:0]      rd_cnt,
  output logic [RMAX*DW-1:0] rdata,
  output logic               rd_acc,
  output logic [DL:0]        occ,
  output logic [DL:0]        free,
  output logic               nempty,
  output logic               nfull,
  output logic               afull,
  output logic               aempty,
  output logic               ovf,
  output logic               udf
);

  localparam int DEPTH = 1 << DL;

  logic [DL:0]   top;
  logic [DL:0]   bot;
  logic [DW-1:0] mem [DEPTH];

  // Status is derived from the registered pointers only, so a same-cycle pop
  // never frees space for a push and a same-cycle push is never visible to a pop.
  assign occ    = top - bot;
  assign free   = (DL+1)'(DEPTH) - occ;
  assign nempty = (occ != '0);
  assign nfull  = (occ != (DL+1)'(DEPTH));
  assign afull  = (int'(occ) >= AF_LVL);
  assign aempty = (int'(occ) <= AE_LVL);

  assign wr_acc = (wr_cnt != '0) && (int'(wr_cnt) <= WMAX) && (int'(wr_cnt) <= int'(free));
  assign rd_acc = (rd_cnt != '0) && (int'(rd_cnt) <= RMAX) && (int'(rd_cnt) <= int'(occ));

  always_comb begin
    rdata = '0;
    for (int i = 0; i < RMAX; i++) begin
      rdata[DW*i +: DW] = mem[bot[DL-1:0] + DL'(i)];
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every always_ff
  // sees the pre-edge values of top/bot regardless of block evaluation order.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      top <= '0;
      bot <= '0;
      ovf <= 1'b0;
      udf <= 1'b0;
    end else begin
      if (wr_acc) begin
        top <= top + (DL+1)'(wr_cnt);
      end else if (wr_cnt != '0) begin
        ovf <= 1'b1;
      end
      if (rd_acc) begin
        bot <= bot + (DL+1)'(rd_cnt);
      end else if (rd_cnt != '0) begin
        udf <= 1'b1;
      end
    end
  end

  // NOTE: storage is deliberately left out of reset; occupancy alone defines which
  // words are meaningful, and a reset-free array maps onto plain RAM.
  always_ff @(posedge clk) begin
    if (!rst && !clr && wr_acc) begin
      for (int i = 0; i < WMAX; i++) begin
        if (i < int'(wr_cnt)) begin
          mem[top[DL-1:0] + DL'(i)] <= wdata[DW*i +: DW];
        end
      end
    end
  end

endmodule

// File: tb/tb_sync_fifo_mw.sv
// Self-checking bench for sync_fifo_mw: directed test-plan steps followed by random
// traffic, all compared against a word-queue reference model.
module tb_sync_fifo_mw;

  localparam int DW = 8, DL = 3, WMAX = 2, RMAX = 2, DEPTH = 8, CW = 2;
  localparam int AF = DEPTH - WMAX, AE = RMAX;

  logic               clk = 1'b0;
  logic               rst, clr;
  logic [CW-1:0]      wr_cnt, rd_cnt;
  logic [WMAX*DW-1:0] wdata;
  logic [RMAX*DW-1:0] rdata;
  logic               wr_acc, rd_acc, nempty, nfull, afull, aempty, ovf, udf;
  logic [DL:0]        occ, free;

  int tests = 0;
  int fails = 0;

  byte unsigned q[$];
  bit           m_ovf, m_udf;

  always #5 clk = ~clk;

  sync_fifo_mw #(.DW(DW), .DL(DL), .WMAX(WMAX), .RMAX(RMAX)) dut (
    .clk(clk), .rst(rst), .clr(clr),
    .wr_cnt(wr_cnt), .wdata(wdata), .wr_acc(wr_acc),
    .rd_cnt(rd_cnt), .rdata(rdata), .rd_acc(rd_acc),
    .occ(occ), .free(free), .nempty(nempty), .nfull(nfull),
    .afull(afull), .aempty(aempty), .ovf(ovf), .udf(udf)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_status();
    int n;
    n = q.size();
    check("occ",    32'(occ),    32'(n));
    check("free",   32'(free),   32'(DEPTH - n));
    check("nempty", 32'(nempty), 32'(n != 0));
    check("nfull",  32'(nfull),  32'(n != DEPTH));
    check("afull",  32'(afull),  32'(n >= AF));
    check("aempty", 32'(aempty), 32'(n <= AE));
    check("ovf",    32'(ovf),    32'(m_ovf));
    check("udf",    32'(udf),    32'(m_udf));
  endtask

  // One clock cycle: drive inputs, check acceptance and head words before the edge,
  // advance the model after the edge and check every status output.
  task automatic step(input bit r, input bit c, input int wc, input int rc, input logic [15:0] wd);
    int  n;
    bit  wa, ra;
    rst = r; clr = c; wr_cnt = CW'(wc); rd_cnt = CW'(rc); wdata = wd;
    #1;
    n  = q.size();
    wa = (wc != 0) && (wc <= WMAX) && (wc <= DEPTH - n);
    ra = (rc != 0) && (rc <= RMAX) && (rc <= n);
    check("wr_acc", 32'(wr_acc), 32'(wa));
    check("rd_acc", 32'(rd_acc), 32'(ra));
    for (int i = 0; i < RMAX; i++)
      if (i < n) check($sformatf("rdata%0d", i), 32'(rdata[DW*i +: DW]), 32'(q[i]));
    @(posedge clk);
    #1;
    if (r || c) begin
      q.delete();
      m_ovf = 1'b0;
      m_udf = 1'b0;
    end else begin
      if (ra) for (int i = 0; i < rc; i++) void'(q.pop_front());
      else if (rc != 0) m_udf = 1'b1;
      if (wa) for (int i = 0; i < wc; i++) q.push_back(wd[DW*i +: DW]);
      else if (wc != 0) m_ovf = 1'b1;
    end
    check_status();
  endtask

  initial begin
    m_ovf = 1'b0;
    m_udf = 1'b0;

    // Reset state, then fill to full; afull rises at occ=6.
    step(1, 0, 0, 0, 16'h0);
    check("rst_occ", 32'(occ), 32'd0);
    check("rst_free", 32'(free), 32'd8);
    step(0, 0, 2, 0, 16'h1211);
    step(0, 0, 2, 0, 16'h1413);
    step(0, 0, 2, 0, 16'h1615);
    check("afull_at6", 32'(afull), 32'd1);
    step(0, 0, 2, 0, 16'h1817);
    check("full_nfull", 32'(nfull), 32'd0);
    check("full_occ", 32'(occ), 32'd8);

    // Ordering through address wrap: 0x01..0x0B, popping 2 per cycle.
    step(1, 0, 0, 0, 16'h0);
    step(0, 0, 2, 0, 16'h0201);
    step(0, 0, 2, 2, 16'h0403);
    step(0, 0, 2, 2, 16'h0605);
    step(0, 0, 2, 2, 16'h0807);
    step(0, 0, 2, 2, 16'h0A09);
    step(0, 0, 1, 2, 16'h000B);
    step(0, 0, 0, 1, 16'h0);
    check("order_empty", 32'(nempty), 32'd0);

    // Overflow at occ=7, sticky, then a fitting push is accepted.
    step(1, 0, 0, 0, 16'h0);
    step(0, 0, 2, 0, 16'h2221);
    step(0, 0, 2, 0, 16'h2423);
    step(0, 0, 2, 0, 16'h2625);
    step(0, 0, 1, 0, 16'h0027);
    step(0, 0, 2, 0, 16'h2928);
    check("ovf_set", 32'(ovf), 32'd1);
    step(0, 0, 0, 0, 16'h0);
    check("ovf_held", 32'(ovf), 32'd1);
    step(0, 0, 1, 0, 16'h002A);
    check("ovf_fill", 32'(occ), 32'd8);

    // Underflow at occ=1, then a legal single pop.
    step(1, 0, 0, 0, 16'h0);
    step(0, 0, 1, 0, 16'h0031);
    step(0, 0, 0, 2, 16'h0);
    check("udf_set", 32'(udf), 32'd1);
    step(0, 0, 0, 1, 16'h0);

    // Simultaneous push/pop, and the full-FIFO equal swap that rejects the push.
    step(1, 0, 0, 0, 16'h0);
    step(0, 0, 2, 0, 16'h4241);
    step(0, 0, 2, 0, 16'h4443);
    step(0, 0, 2, 1, 16'h4645);
    check("sim_occ5", 32'(occ), 32'd5);
    step(0, 0, 2, 0, 16'h4847);
    step(0, 0, 1, 0, 16'h0049);
    step(0, 0, 1, 1, 16'h004A);
    check("swap_occ7", 32'(occ), 32'd7);

    // Flush mid-traffic with ovf set; illegal wr_cnt=3 on an empty FIFO.
    step(1, 0, 0, 0, 16'h0);
    step(0, 0, 2, 0, 16'h5251);
    step(0, 0, 2, 0, 16'h5453);
    step(0, 0, 1, 0, 16'h0055);
    step(0, 0, 3, 0, 16'h5756);
    step(0, 1, 2, 0, 16'h5958);
    check("clr_ovf", 32'(ovf), 32'd0);
    step(0, 0, 3, 0, 16'h5B5A);
    check("illegal_ovf", 32'(ovf), 32'd1);

    // Random traffic with occasional flushes.
    step(1, 0, 0, 0, 16'h0);
    for (int k = 0; k < 400; k++) begin
      step(0, ($urandom_range(0, 39) == 0), int'($urandom_range(0, 3)),
           int'($urandom_range(0, 3)), 16'($urandom));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
